// File: rtl/pc_sequencer.sv
// Program counter sequencer: boot cycle, ready/stall hold, sequential/branch/jump/jr next-PC,
// sticky fault on a misaligned jr, and saturating retire / taken-branch counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 imem_ready,
    input  logic                 Branch_deci,
    input  logic                 Jump,
    input  logic                 Jr,
    input  logic [31:0]          branch_offset,
    input  logic [25:0]          jump_index,
    input  logic [31:0]          jr_target,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 pc_valid,
    output logic                 redirect,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] instr_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, FLT} state_t;

    state_t      state, state_nxt;
    logic        retire, jr_bad;
    logic [31:0] boff_sh, pc_nxt;
    logic        redirect_nxt, count_nxt, taken_nxt;

    assign pc_plus4 = pc + 32'd4;
    assign boff_sh  = branch_offset << 2;
    assign retire   = (state == RUN) && imem_ready && !stall;
    assign jr_bad   = (jr_target[1:0] != 2'b00);
    assign pc_valid = (state == RUN);
    assign fault    = (state == FLT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (retire && Jr && jr_bad) state_nxt = FLT;
            FLT:     state_nxt = FLT;
            default: state_nxt = BOOT;
        endcase
    end

    // Highest-priority control wins; a misaligned jr retires nothing.
    always_comb begin
        pc_nxt       = pc;
        redirect_nxt = 1'b0;
        count_nxt    = 1'b0;
        taken_nxt    = 1'b0;
        if (retire) begin
            if (Jr) begin
                if (!jr_bad) begin
                    pc_nxt       = jr_target;
                    redirect_nxt = 1'b1;
                    count_nxt    = 1'b1;
                end
            end else if (Jump) begin
                pc_nxt       = {pc_plus4[31:28], jump_index, 2'b00};
                redirect_nxt = 1'b1;
                count_nxt    = 1'b1;
            end else if (Branch_deci) begin
                pc_nxt       = pc_plus4 + boff_sh;
                redirect_nxt = 1'b1;
                count_nxt    = 1'b1;
                taken_nxt    = 1'b1;
            end else begin
                pc_nxt    = pc_plus4;
                count_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_VECTOR;
            redirect  <= 1'b0;
            instr_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            pc       <= pc_nxt;
            redirect <= redirect_nxt;
            if (count_nxt && instr_cnt != {CNT_WIDTH{1'b1}}) instr_cnt <= instr_cnt + 1'b1;
            if (taken_nxt && taken_cnt != {CNT_WIDTH{1'b1}}) taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule
